// File: rtl/pll_chg_arb.sv
// pll_chg_arb: round-robin arbiter and sequencer for PLL reconfiguration.
// Two requesters (A = host, B = sweep engine) share the PLL_ADDR/PLL_CHG
// pair. Each granted change issues one PLL_CHG strobe, waits for lock to
// drop and return, waits a settle time, then pulses the requester's ACK.
//
// Ports:
//   CLK, RSTXO         clock; asynchronous active-low reset
//   REQ_A/ADDR_A/ACK_A host request level, target address, done pulse
//   REQ_B/ADDR_B/ACK_B sweep request level, target address, done pulse
//   LOCKED             PLL lock (asynchronous, synchronized internally)
//   PLL_ADDR, PLL_CHG  address and one-cycle strobe to the PLL control block
//   BUSY               high whenever the sequencer is not idle
//   CUR_ADDR/CUR_VALID last successfully applied address and its validity
//   LOCK_ERR           sticky: last change timed out waiting for lock
//
// Optional feature macro: PLL_CHG_SKIP_SAME_EN -- a grant whose address
// already matches a valid CUR_ADDR completes without strobing the PLL.
module pll_chg_arb #(
  parameter int unsigned CW       = 16,
  parameter int unsigned UNLK_CYC = 64,
  parameter int unsigned LOCK_TMO = 65535,
  parameter int unsigned SETTLE   = 16
) (
  input  logic       CLK,
  input  logic       RSTXO,
  input  logic       REQ_A,
  input  logic [7:0] ADDR_A,
  output logic       ACK_A,
  input  logic       REQ_B,
  input  logic [7:0] ADDR_B,
  output logic       ACK_B,
  input  logic       LOCKED,
  output logic [7:0] PLL_ADDR,
  output logic       PLL_CHG,
  output logic       BUSY,
  output logic [7:0] CUR_ADDR,
  output logic       CUR_VALID,
  output logic       LOCK_ERR
);

  localparam int unsigned AW = 8;

  // Limits compared against the number of cycles spent in the current state.
  localparam logic [CW:0] UNLK_LIM   = (CW+1)'(UNLK_CYC);
  localparam logic [CW:0] TMO_LIM    = (CW+1)'(LOCK_TMO);
  localparam logic [CW:0] SETTLE_LIM = (CW+1)'(SETTLE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_WAIT_UNLK,
    ST_WAIT_LK,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [CW:0]   elapsed;
  logic          lk_meta_q, lk_q;
  logic          gnt_b_q, gnt_b_d;
  logic          prio_b_q, prio_b_d;
  logic          win_b;
  logic [AW-1:0] pll_addr_q, pll_addr_d;
  logic          pll_chg_q, pll_chg_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic          cur_valid_q, cur_valid_d;
  logic          lock_err_q, lock_err_d;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      lk_meta_q <= 1'b0;
      lk_q      <= 1'b0;
    end else begin
      lk_meta_q <= LOCKED;
      lk_q      <= lk_meta_q;
    end
  end

  // Saturating per-state cycle counter; elapsed includes the current cycle.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign elapsed = {1'b0, cnt_q} + (CW+1)'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_b_d     = gnt_b_q;
    prio_b_d    = prio_b_q;
    pll_addr_d  = pll_addr_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    lock_err_d  = lock_err_q;
    win_b       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (REQ_A || REQ_B) begin
          // B wins when alone, or when both request and B holds priority.
          win_b      = REQ_B && (!REQ_A || prio_b_q);
          state_d    = ST_GRANT;
          gnt_b_d    = win_b;
          prio_b_d   = !win_b;
          pll_addr_d = win_b ? ADDR_B : ADDR_A;
        end
      end
      ST_GRANT: begin
`ifdef PLL_CHG_SKIP_SAME_EN
        if (cur_valid_q && (pll_addr_q == cur_addr_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
`else
        state_d = ST_ISSUE;
`endif
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_UNLK;
      end
      ST_WAIT_UNLK: begin
        // A PLL that never visibly drops lock is tolerated after the limit.
        if (!lk_q || (elapsed >= UNLK_LIM)) begin
          state_d = ST_WAIT_LK;
        end
      end
      ST_WAIT_LK: begin
        if (lk_q) begin
          state_d = ST_SETTLE;
        end else if (elapsed >= TMO_LIM) begin
          state_d     = ST_DONE;
          cur_valid_d = 1'b0;
          lock_err_d  = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Lock must stay high for the whole window; any drop restarts it.
        if (!lk_q) begin
          state_d = ST_WAIT_LK;
        end else if (elapsed >= SETTLE_LIM) begin
          state_d     = ST_DONE;
          cur_addr_d  = pll_addr_q;
          cur_valid_d = 1'b1;
          lock_err_d  = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_d     = (state_d != state_q) ? '0 : cnt_inc;
    pll_chg_d = (state_d == ST_ISSUE);
    ack_a_d   = (state_d == ST_DONE) && !gnt_b_d;
    ack_b_d   = (state_d == ST_DONE) && gnt_b_d;
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTXO) begin
    if (!RSTXO) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_b_q     <= 1'b0;
      prio_b_q    <= 1'b0;
      pll_addr_q  <= '0;
      pll_chg_q   <= 1'b0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      lock_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_b_q     <= gnt_b_d;
      prio_b_q    <= prio_b_d;
      pll_addr_q  <= pll_addr_d;
      pll_chg_q   <= pll_chg_d;
      ack_a_q     <= ack_a_d;
      ack_b_q     <= ack_b_d;
      busy_q      <= busy_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      lock_err_q  <= lock_err_d;
    end
  end

  assign ACK_A     = ack_a_q;
  assign ACK_B     = ack_b_q;
  assign PLL_ADDR  = pll_addr_q;
  assign PLL_CHG   = pll_chg_q;
  assign BUSY      = busy_q;
  assign CUR_ADDR  = cur_addr_q;
  assign CUR_VALID = cur_valid_q;
  assign LOCK_ERR  = lock_err_q;

endmodule

// File: tb/tb_pll_chg_arb.sv
// Testbench for pll_chg_arb: scoreboard of expected completions, a small
// PLL lock model driven off the observed PLL_CHG strobe, and exact latency
// checks derived from the sequencer timing.
module tb_pll_chg_arb;

  logic       CLK = 1'b0;
  logic       RSTXO;
  logic       REQ_A, REQ_B;
  logic [7:0] ADDR_A, ADDR_B;
  logic       ACK_A, ACK_B;
  logic       LOCKED;
  logic [7:0] PLL_ADDR;
  logic       PLL_CHG;
  logic       BUSY;
  logic [7:0] CUR_ADDR;
  logic       CUR_VALID;
  logic       LOCK_ERR;

  pll_chg_arb #(
    .CW(16), .UNLK_CYC(64), .LOCK_TMO(200), .SETTLE(16)
  ) dut (
    .CLK(CLK), .RSTXO(RSTXO),
    .REQ_A(REQ_A), .ADDR_A(ADDR_A), .ACK_A(ACK_A),
    .REQ_B(REQ_B), .ADDR_B(ADDR_B), .ACK_B(ACK_B),
    .LOCKED(LOCKED),
    .PLL_ADDR(PLL_ADDR), .PLL_CHG(PLL_CHG), .BUSY(BUSY),
    .CUR_ADDR(CUR_ADDR), .CUR_VALID(CUR_VALID), .LOCK_ERR(LOCK_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       b;
    logic [7:0] addr;
    logic       ok;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_miscmp = 0;
  int cyc = 0;
  int chg_cnt = 0, chg_cyc = 0;
  int ack_cnt = 0, ack_cyc = 0;
  logic last_ack_a, last_ack_b;

  // Lock model: after a strobe, LOCKED falls drop_dly cycles later and
  // returns low_len cycles after that (0 = never falls, -1 = never returns).
  int drop_dly = 3;
  int low_len = 100;
  int glitch_en = 0;
  int t_fall = -1, t_rise = -1, g_fall = -1, g_rise = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic b, input logic [7:0] addr, input logic ok);
    exp_t e;
    e.b = b;
    e.addr = addr;
    e.ok = ok;
    exp_q.push_back(e);
  endtask

  // One clock: sample outputs at the falling edge, run the lock model,
  // score completions and release the acknowledged request.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    cyc++;
    last_ack_a = 1'b0;
    last_ack_b = 1'b0;
    if (cyc == t_fall) LOCKED = 1'b0;
    if (cyc == t_rise) LOCKED = 1'b1;
    if (cyc == g_fall) LOCKED = 1'b0;
    if (cyc == g_rise) LOCKED = 1'b1;
    if (PLL_CHG) begin
      chg_cnt++;
      chg_cyc = cyc;
      if (exp_q.size() > 0) chk("chg_addr", 32'(PLL_ADDR), 32'(exp_q[0].addr));
      t_fall = (low_len != 0) ? cyc + drop_dly : -1;
      t_rise = (low_len > 0) ? t_fall + low_len : -1;
      g_fall = (glitch_en != 0) ? t_rise + 9 : -1;
      g_rise = (glitch_en != 0) ? g_fall + 5 : -1;
    end
    if (ACK_A || ACK_B) begin
      ack_cnt++;
      ack_cyc = cyc;
      last_ack_a = ACK_A;
      last_ack_b = ACK_B;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'({ACK_B, ACK_A}), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("ack_who", 32'({ACK_B, ACK_A}), e.b ? 32'(2) : 32'(1));
        chk("cur_valid", 32'(CUR_VALID), 32'(e.ok));
        chk("lock_err", 32'(LOCK_ERR), 32'(!e.ok));
        if (e.ok) chk("cur_addr", 32'(CUR_ADDR), 32'(e.addr));
      end
      if (ACK_A) REQ_A = 1'b0;
      if (ACK_B) REQ_B = 1'b0;
    end
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      step();
      n++;
    end
    if (ack_cnt < target) chk("ack_wait", 32'(ack_cnt), 32'(target));
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_ack_a"}, 32'(ACK_A), 32'(0));
    chk({tag, "_ack_b"}, 32'(ACK_B), 32'(0));
    chk({tag, "_chg"}, 32'(PLL_CHG), 32'(0));
    chk({tag, "_pll_addr"}, 32'(PLL_ADDR), 32'(0));
    chk({tag, "_busy"}, 32'(BUSY), 32'(0));
    chk({tag, "_cur_addr"}, 32'(CUR_ADDR), 32'(0));
    chk({tag, "_cur_valid"}, 32'(CUR_VALID), 32'(0));
    chk({tag, "_lock_err"}, 32'(LOCK_ERR), 32'(0));
  endtask

  initial begin
    int r, base_chg, base_ack, n;
    logic pa, pb, ra, rb;

    RSTXO = 1'b0;
    REQ_A = 1'b0;
    REQ_B = 1'b0;
    ADDR_A = 8'h00;
    ADDR_B = 8'h00;
    LOCKED = 1'b1;
    repeat (3) step();
    check_rst("rst");
    RSTXO = 1'b1;
    repeat (3) step();

    // Single host request, normal unlock/relock.
    base_chg = chg_cnt;
    r = cyc;
    ADDR_A = 8'h12;
    REQ_A = 1'b1;
    push_exp(1'b0, 8'h12, 1'b1);
    wait_acks(ack_cnt + 1, 400);
    chk("t1_chg_lat", 32'(chg_cyc - r), 32'(2));
    chk("t1_chg_cnt", 32'(chg_cnt - base_chg), 32'(1));
    chk("t1_ack_lat", 32'(ack_cyc - r), 32'(124));
    repeat (5) step();

    // Sweep request for the address already applied.
    base_chg = chg_cnt;
    r = cyc;
    ADDR_B = 8'h12;
    REQ_B = 1'b1;
    push_exp(1'b1, 8'h12, 1'b1);
    wait_acks(ack_cnt + 1, 400);
`ifdef PLL_CHG_SKIP_SAME_EN
    chk("t2_ack_lat", 32'(ack_cyc - r), 32'(2));
    chk("t2_chg_cnt", 32'(chg_cnt - base_chg), 32'(0));
`else
    chk("t2_ack_lat", 32'(ack_cyc - r), 32'(124));
    chk("t2_chg_cnt", 32'(chg_cnt - base_chg), 32'(1));
`endif
    repeat (5) step();

    // Simultaneous requests, each re-raised once: grants A, B, A, B.
    base_ack = ack_cnt;
    push_exp(1'b0, 8'h21, 1'b1);
    push_exp(1'b1, 8'h34, 1'b1);
    push_exp(1'b0, 8'h23, 1'b1);
    push_exp(1'b1, 8'h36, 1'b1);
    ADDR_A = 8'h21;
    ADDR_B = 8'h34;
    REQ_A = 1'b1;
    REQ_B = 1'b1;
    pa = 1'b0; pb = 1'b0; ra = 1'b0; rb = 1'b0;
    n = 0;
    while (ack_cnt < base_ack + 4 && n < 1000) begin
      step();
      n++;
      if (pa) begin REQ_A = 1'b1; ADDR_A = 8'h23; pa = 1'b0; end
      if (pb) begin REQ_B = 1'b1; ADDR_B = 8'h36; pb = 1'b0; end
      if (last_ack_a && !ra) begin pa = 1'b1; ra = 1'b1; end
      if (last_ack_b && !rb) begin pb = 1'b1; rb = 1'b1; end
    end
    if (ack_cnt < base_ack + 4) chk("rr_wait", 32'(ack_cnt - base_ack), 32'(4));
    repeat (5) step();

    // LOCKED never falls: unlock window expires, then settle.
    low_len = 0;
    base_chg = chg_cnt;
    r = cyc;
    ADDR_A = 8'h44;
    REQ_A = 1'b1;
    push_exp(1'b0, 8'h44, 1'b1);
    wait_acks(ack_cnt + 1, 400);
    chk("t4_ack_lat", 32'(ack_cyc - r), 32'(84));
    chk("t4_chg_cnt", 32'(chg_cnt - base_chg), 32'(1));
    low_len = 100;
    repeat (5) step();

    // Lock glitch in the middle of the settle window.
    glitch_en = 1;
    ADDR_B = 8'h58;
    REQ_B = 1'b1;
    push_exp(1'b1, 8'h58, 1'b1);
    wait_acks(ack_cnt + 1, 400);
    chk("t5_settle_restart", 32'(ack_cyc - g_rise), 32'(19));
    glitch_en = 0;
    repeat (5) step();

    // Lock never returns: timeout, then a good change clears the error.
    low_len = -1;
    r = cyc;
    ADDR_A = 8'h66;
    REQ_A = 1'b1;
    push_exp(1'b0, 8'h66, 1'b0);
    wait_acks(ack_cnt + 1, 600);
    chk("t6_tmo_lat", 32'(ack_cyc - r), 32'(208));
    LOCKED = 1'b1;
    t_fall = -1;
    t_rise = -1;
    low_len = 100;
    repeat (5) step();
    ADDR_A = 8'h77;
    REQ_A = 1'b1;
    push_exp(1'b0, 8'h77, 1'b1);
    wait_acks(ack_cnt + 1, 400);
    repeat (5) step();

    // Reset while waiting for relock aborts without ACK.
    low_len = -1;
    base_chg = chg_cnt;
    ADDR_A = 8'h55;
    REQ_A = 1'b1;
    n = 0;
    while (chg_cnt == base_chg && n < 20) begin
      step();
      n++;
    end
    chk("t7_chg_seen", 32'(chg_cnt - base_chg), 32'(1));
    repeat (40) step();
    base_ack = ack_cnt;
    RSTXO = 1'b0;
    #1;
    check_rst("abort");
    REQ_A = 1'b0;
    LOCKED = 1'b1;
    t_fall = -1;
    t_rise = -1;
    low_len = 100;
    repeat (3) step();
    RSTXO = 1'b1;
    repeat (300) step();
    chk("t7_no_ack", 32'(ack_cnt - base_ack), 32'(0));
    chk("t7_busy", 32'(BUSY), 32'(0));
    chk("t7_cur_valid", 32'(CUR_VALID), 32'(0));

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
